// File: rtl/ula_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, controller states and opcode helpers.
// Latency: not applicable (declarations only).
// Backpressure: not applicable.
package ula_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_EQ  = 3'b110;
    localparam logic [2:0] OP_NEQ = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        EXEC  = 2'd2,
        CAPT  = 2'd3
    } state_t;

    // Anything outside the six opcodes the ALU implements (i.e. 100 and 101).
    function automatic logic op_illegal(input logic [2:0] op);
        return !((op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR) ||
                 (op == OP_NOT) || (op == OP_EQ)  || (op == OP_NEQ));
    endfunction

    // Only add/sub produce a meaningful carry/borrow flag.
    function automatic logic op_has_flag(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin grant: combinational grant from valids and a last-grant pointer.
// Latency: grant is combinational; pointer updates at the accept edge.
// Backpressure: none; the caller qualifies accept with its own ready.
module arb_rr2
    import ula_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0_i,
    input  logic req1_i,
    input  logic accept_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    // last1_q = 1 means requester 1 was granted last, so requester 0 wins a tie.
    logic last1_q;
    logic last1_d;

    // Grant: a lone requester wins; under contention the one not granted last wins.
    always_comb begin
        gnt0_o  = req0_i & (~req1_i | last1_q);
        gnt1_o  = req1_i & (~req0_i | ~last1_q);
        last1_d = accept_i ? gnt1_o : last1_q;
    end

    // Pointer register; reset leaves requester 0 favoured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last1_q <= 1'b1;
        end else begin
            last1_q <= last1_d;
        end
    end

endmodule

// File: rtl/ula_arbitro.sv
// Shares one two-stage ALU between two requesters with round-robin arbitration; optional counters under ULA_ARB_STATS_EN.
// Latency: 4 cycles from accept to a one-cycle response pulse; one op in flight, 1 op per 4 cycles.
// Backpressure: ready only in IDLE for the arbitration winner; responses cannot be stalled.
module ula_arbitro
    import ula_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [2:0]   req0_op,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [2:0]   req1_op,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         req1_ready,
    output logic         resp0_valid,
    output logic [N-1:0] resp0_s,
    output logic         resp0_flag,
    output logic         resp0_err,
    output logic         resp1_valid,
    output logic [N-1:0] resp1_s,
    output logic         resp1_flag,
    output logic         resp1_err,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_opcode,
    input  logic [N-1:0] alu_s,
    input  logic         alu_flag,
    output logic [15:0]  cnt0,
    output logic [15:0]  cnt1
);

    state_t       state_q, state_d;
    logic         gnt0, gnt1;
    logic         accept;
    logic [2:0]   op_q;
    logic [N-1:0] a_q, b_q;
    logic         owner_q;
    logic [N-1:0] cap_s;
    logic         cap_flag, cap_err;
    logic         r0v_q, r1v_q;
    logic [N-1:0] s0_q, s1_q;
    logic         f0_q, f1_q, e0_q, e1_q;

    arb_rr2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req0_i   (req0_valid),
        .req1_i   (req1_valid),
        .accept_i (accept),
        .gnt0_o   (gnt0),
        .gnt1_o   (gnt1)
    );

    // Ready only while idle and only to the winner; accept is the qualified handshake.
    always_comb begin
        req0_ready = (state_q == IDLE) & gnt0;
        req1_ready = (state_q == IDLE) & gnt1;
        accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    end

    // Next state: fixed IDLE -> ISSUE -> EXEC -> CAPT -> IDLE walk, gated by accept.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = EXEC;
            EXEC:    state_d = CAPT;
            CAPT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the accepted op; these drive the ALU unchanged until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= 3'b000;
            a_q     <= '0;
            b_q     <= '0;
            owner_q <= 1'b0;
        end else if (accept) begin
            if (req1_ready) begin
                op_q    <= req1_op;
                a_q     <= req1_a;
                b_q     <= req1_b;
                owner_q <= 1'b1;
            end else begin
                op_q    <= req0_op;
                a_q     <= req0_a;
                b_q     <= req0_b;
                owner_q <= 1'b0;
            end
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_opcode = op_q;

    // Result shaping: illegal ops discard the ALU output; flag kept only for add/sub.
    always_comb begin
        cap_s    = alu_s;
        cap_flag = op_has_flag(op_q) ? alu_flag : 1'b0;
        cap_err  = 1'b0;
        if (op_illegal(op_q)) begin
            cap_s    = '0;
            cap_flag = 1'b0;
            cap_err  = 1'b1;
        end
    end

    // Capture into the owner's response registers at the end of CAPT and pulse valid next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r0v_q <= 1'b0;
            r1v_q <= 1'b0;
            s0_q  <= '0;
            s1_q  <= '0;
            f0_q  <= 1'b0;
            f1_q  <= 1'b0;
            e0_q  <= 1'b0;
            e1_q  <= 1'b0;
        end else begin
            r0v_q <= (state_q == CAPT) && !owner_q;
            r1v_q <= (state_q == CAPT) && owner_q;
            if ((state_q == CAPT) && !owner_q) begin
                s0_q <= cap_s;
                f0_q <= cap_flag;
                e0_q <= cap_err;
            end
            if ((state_q == CAPT) && owner_q) begin
                s1_q <= cap_s;
                f1_q <= cap_flag;
                e1_q <= cap_err;
            end
        end
    end

    assign resp0_valid = r0v_q;
    assign resp0_s     = s0_q;
    assign resp0_flag  = f0_q;
    assign resp0_err   = e0_q;
    assign resp1_valid = r1v_q;
    assign resp1_s     = s1_q;
    assign resp1_flag  = f1_q;
    assign resp1_err   = e1_q;

`ifdef ULA_ARB_STATS_EN
    logic [15:0] cnt0_q, cnt1_q;

    // Completed-op counters, one per requester, wrapping naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= 16'd0;
            cnt1_q <= 16'd0;
        end else begin
            if (r0v_q) cnt0_q <= cnt0_q + 16'd1;
            if (r1v_q) cnt1_q <= cnt1_q + 16'd1;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`else
    assign cnt0 = 16'd0;
    assign cnt1 = 16'd0;
`endif

endmodule

// File: tb/tb_ula_arbitro.sv
// Directed bench for ula_arbitro with a behavioural two-stage ALU attached.
// Latency: n/a.
// Backpressure: n/a.
module tb_ula_arbitro;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [2:0]  req0_op = 3'b0, req1_op = 3'b0;
    logic [7:0]  req0_a = 8'h0, req0_b = 8'h0, req1_a = 8'h0, req1_b = 8'h0;
    logic        req0_ready, req1_ready;
    logic        resp0_valid, resp1_valid;
    logic [7:0]  resp0_s, resp1_s;
    logic        resp0_flag, resp1_flag, resp0_err, resp1_err;
    logic [7:0]  alu_a, alu_b;
    logic [2:0]  alu_opcode;
    logic [15:0] cnt0, cnt1;

    // Behavioural ALU: operand registers, then result register.
    logic [7:0] ra = 8'h0, rb = 8'h0, rs = 8'h0;
    logic [2:0] rop = 3'b0;
    logic       rf = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ra  <= alu_a;
        rb  <= alu_b;
        rop <= alu_opcode;
        case (rop)
            3'b000:  {rf, rs} <= {1'b0, ra} + {1'b0, rb};
            3'b001:  begin rs <= ra - rb; rf <= (ra < rb); end
            3'b010:  begin rs <= ra ^ rb; rf <= 1'b1; end
            3'b011:  begin rs <= ~ra; rf <= 1'b1; end
            3'b110:  begin rs <= (ra == rb) ? 8'h01 : 8'h00; rf <= 1'b1; end
            3'b111:  begin rs <= (ra != rb) ? 8'h01 : 8'h00; rf <= 1'b1; end
            default: begin rs <= 8'hA5; rf <= 1'b1; end
        endcase
    end

    ula_arbitro #(.N(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .resp0_valid(resp0_valid), .resp0_s(resp0_s), .resp0_flag(resp0_flag), .resp0_err(resp0_err),
        .resp1_valid(resp1_valid), .resp1_s(resp1_s), .resp1_flag(resp1_flag), .resp1_err(resp1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_s(rs), .alu_flag(rf),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    typedef struct {
        logic       id;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic       f;
        logic       e;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    int         stray  = 0;
    int         viol   = 0;
    int         since  = 99;
    int         e_cnt[2];
    logic [7:0] prev_s[2];
    vec_t       vt[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Ready must stay low during the three cycles following an accept.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            since = 99;
        end else begin
            if (since < 1000) since++;
            if ((req0_ready || req1_ready) && since < 4) viol++;
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) since = 0;
        end
    end

    task automatic do_op(input vec_t v, input int idx);
        int   n;
        int   lat;
        logic rdy, rv, got;
        if (v.id == 1'b0) begin
            req0_valid = 1'b1; req0_op = v.op; req0_a = v.a; req0_b = v.b;
        end else begin
            req1_valid = 1'b1; req1_op = v.op; req1_a = v.a; req1_b = v.b;
        end
        #1;
        n   = 0;
        rdy = v.id ? req1_ready : req0_ready;
        while (!rdy && n < 10) begin
            @(negedge clk); #1; n++;
            rdy = v.id ? req1_ready : req0_ready;
        end
        chk($sformatf("vec%0d ready", idx), rdy, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            rv = v.id ? resp1_valid : resp0_valid;
            if (v.id ? resp0_valid : resp1_valid) stray++;
            if (lat == 3) chk($sformatf("vec%0d held s", idx), v.id ? resp1_s : resp0_s, prev_s[v.id]);
            if (rv) got = 1'b1;
        end
        chk($sformatf("vec%0d latency", idx), lat, 4);
        chk($sformatf("vec%0d s", idx), v.id ? resp1_s : resp0_s, v.s);
        chk($sformatf("vec%0d flag", idx), v.id ? resp1_flag : resp0_flag, v.f);
        chk($sformatf("vec%0d err", idx), v.id ? resp1_err : resp0_err, v.e);
        prev_s[v.id] = v.s;
        e_cnt[v.id]++;
    endtask

    initial begin #100000; $display("FAIL watchdog: run did not finish"); $fatal(1, "timeout"); end

    initial begin
        int acc0, acc1, r0, r1, ng, n0, n1, rsp0, rsp1, nresp;
        int g[6];
        vec_t v;

        vt[0] = '{1'b0, 3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vt[1] = '{1'b0, 3'b001, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0};
        vt[2] = '{1'b1, 3'b001, 8'h07, 8'h05, 8'h02, 1'b0, 1'b0};
        vt[3] = '{1'b1, 3'b010, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0};
        vt[4] = '{1'b0, 3'b011, 8'h3C, 8'h00, 8'hC3, 1'b0, 1'b0};
        vt[5] = '{1'b1, 3'b110, 8'h3C, 8'h3C, 8'h01, 1'b0, 1'b0};
        vt[6] = '{1'b1, 3'b111, 8'h3C, 8'h3C, 8'h00, 1'b0, 1'b0};
        vt[7] = '{1'b0, 3'b101, 8'h55, 8'hAA, 8'h00, 1'b0, 1'b1};
        vt[8] = '{1'b1, 3'b100, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1};
        vt[9] = '{1'b0, 3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0};
        e_cnt[0] = 0; e_cnt[1] = 0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rst resp0_valid", resp0_valid, 0); chk("rst resp1_valid", resp1_valid, 0);
        chk("rst resp0_s", resp0_s, 0);         chk("rst resp1_s", resp1_s, 0);
        chk("rst alu_a", alu_a, 0); chk("rst alu_b", alu_b, 0); chk("rst alu_opcode", alu_opcode, 0);
        chk("rst cnt0", cnt0, 0);   chk("rst cnt1", cnt1, 0);

        // Contention from reset: req0 first, req1 four cycles later.
        @(negedge clk);
        acc0 = -1; acc1 = -1; r0 = -1; r1 = -1;
        req0_valid = 1'b1; req0_op = 3'b000; req0_a = 8'h7F; req0_b = 8'h01;
        req1_valid = 1'b1; req1_op = 3'b010; req1_a = 8'hF0; req1_b = 8'h0F;
        for (int c = 0; c < 14; c++) begin
            #1;
            if (c == 0) begin
                chk("c0 ready0", req0_ready, 1);
                chk("c0 ready1", req1_ready, 0);
            end
            if (req0_valid && req0_ready && acc0 < 0) acc0 = c;
            if (req1_valid && req1_ready && acc1 < 0) acc1 = c;
            if (resp0_valid) begin
                r0 = c;
                chk("c resp0 s", resp0_s, 8'h80); chk("c resp0 flag", resp0_flag, 0);
            end
            if (resp1_valid) begin
                r1 = c;
                chk("c resp1 s", resp1_s, 8'hFF); chk("c resp1 flag", resp1_flag, 0);
            end
            @(posedge clk); #1;
            if (acc0 == c) req0_valid = 1'b0;
            if (acc1 == c) req1_valid = 1'b0;
            @(negedge clk);
        end
        chk("c acc0 cycle", acc0, 0); chk("c acc1 cycle", acc1, 4);
        chk("c resp0 cycle", r0, 4);  chk("c resp1 cycle", r1, 8);
        e_cnt[0]++; e_cnt[1]++;

        // Both held valid for six ops: grants alternate.
        ng = 0; n0 = 0; n1 = 0; rsp0 = 0; rsp1 = 0;
        req0_valid = 1'b1; req0_op = 3'b000; req0_a = 8'h01; req0_b = 8'h01;
        req1_valid = 1'b1; req1_op = 3'b001; req1_a = 8'h09; req1_b = 8'h04;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (req0_valid && req0_ready) begin
                if (ng < 6) g[ng] = 0;
                ng++; n0++;
            end else if (req1_valid && req1_ready) begin
                if (ng < 6) g[ng] = 1;
                ng++; n1++;
            end
            if (resp0_valid) begin rsp0++; chk("alt resp0 s", resp0_s, 8'h02); end
            if (resp1_valid) begin rsp1++; chk("alt resp1 s", resp1_s, 8'h05); end
            @(posedge clk); #1;
            if (n0 >= 3) req0_valid = 1'b0;
            if (n1 >= 3) req1_valid = 1'b0;
            @(negedge clk);
        end
        chk("alt grants", ng, 6);
        for (int i = 0; i < 6; i++) chk($sformatf("alt grant%0d", i), g[i], i % 2);
        chk("alt resp0 count", rsp0, 3); chk("alt resp1 count", rsp1, 3);
        e_cnt[0] += 3; e_cnt[1] += 3;
        prev_s[0] = 8'h02; prev_s[1] = 8'h05;

        // Table of single ops, issued back to back.
        for (int i = 0; i < 10; i++) do_op(vt[i], i);

        // Reset during EXEC aborts the op.
        req0_valid = 1'b1; req0_op = 3'b000; req0_a = 8'h10; req0_b = 8'h20;
        #1;
        chk("abort ready0", req0_ready, 1);
        @(posedge clk); #1; req0_valid = 1'b0;
        @(posedge clk);
        @(negedge clk); rst = 1'b1;
        #1;
        chk("abort resp0_s", resp0_s, 0); chk("abort resp0_flag", resp0_flag, 0);
        chk("abort resp1_err", resp1_err, 0); chk("abort resp1_s", resp1_s, 0);
        chk("abort alu_a", alu_a, 0); chk("abort alu_opcode", alu_opcode, 0);
        chk("abort cnt0", cnt0, 0); chk("abort cnt1", cnt1, 0);
        @(negedge clk); rst = 1'b0;
        prev_s[0] = 8'h00; prev_s[1] = 8'h00;
        e_cnt[0] = 0; e_cnt[1] = 0;
        nresp = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp0_valid || resp1_valid) nresp++;
        end
        chk("abort no resp", nresp, 0);

        // Pointer is back to favouring req0 under contention.
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("post-rst ready0", req0_ready, 1);
        chk("post-rst ready1", req1_ready, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        v = '{1'b1, 3'b000, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0};
        do_op(v, 10);

        repeat (3) @(negedge clk);
`ifdef ULA_ARB_STATS_EN
        chk("cnt0 final", cnt0, e_cnt[0]);
        chk("cnt1 final", cnt1, e_cnt[1]);
`else
        chk("cnt0 final", cnt0, 0);
        chk("cnt1 final", cnt1, 0);
`endif
        chk("stray responses", stray, 0);
        chk("ready outside idle", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ula_arbitro.md
# ula_arbitro

Two-requester controller that shares one 8-bit ALU (`ula`, opcodes 000 add, 001 sub, 010 xor, 011 not, 110 eq, 111 neq) between two independent clients. It accepts one operation at a time over a valid/ready handshake and arbitrates round-robin. It sequences the ALU's two-register pipeline (operand registers, then result register), captures result and carry/borrow flag, and returns them to the owning requester as a one-cycle response pulse. It sits between the client blocks and the ALU instance; the ALU's inputs are driven only by this block.

## Interface
- `N`, 8: data width of operands and result.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0_valid`, `req1_valid` in 1: request present.
- `req0_op`, `req1_op` in 3: ALU opcode.
- `req0_a`, `req0_b`, `req1_a`, `req1_b` in N: operands.
- `req0_ready`, `req1_ready` out 1: request accepted this cycle when valid&&ready.
- `resp0_valid`, `resp1_valid` out 1: one-cycle completion pulse.
- `resp0_s`, `resp1_s` out N: result, held until the next response to the same requester.
- `resp0_flag`, `resp1_flag` out 1: captured ALU flag.
- `resp0_err`, `resp1_err` out 1: illegal opcode (100/101).
- `alu_a`, `alu_b` out N; `alu_opcode` out 3: ALU inputs.
- `alu_s` in N; `alu_flag` in 1: ALU outputs.
- `cnt0`, `cnt1` out 16: completed-op counters (see Configuration).

## Operation
- FSM states:
  - IDLE → ISSUE on accept.
  - ISSUE → EXEC.
  - EXEC → CAPT.
  - CAPT → IDLE.
  - No other transitions.
- Readiness:
  - `reqX_ready` is asserted only in IDLE, and only for the arbitration winner.
  - It is combinational from both valids and the last-grant pointer.
- Arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the requester not granted last wins.
  - The pointer updates on accept only.
- On accept:
  - Latch op, a, b and the owner id.
  - `alu_a`, `alu_b` and `alu_opcode` are driven from these latches and held constant through ISSUE, EXEC and CAPT.
- Capture in CAPT:
  - Sample `alu_s` and `alu_flag` into the owner's response registers.
  - At the end of CAPT, pulse `respX_valid` in the following cycle.
  - Flag is meaningful only for op 000/001; for all other ops it is stored as 0.
- Illegal op (100/101):
  - Accepted normally and the same states are traversed, with identical latency.
  - The ALU output is ignored; the block returns s=0, flag=0, err=1.
- Responses have no backpressure; a requester must sink the pulse.
- Reset values:
  - State IDLE; pointer favours requester 0.
  - All `resp*` outputs 0.
  - `alu_*` outputs 0; counters 0.
- Reset mid-operation aborts the in-flight op with no response.

## Timing
- Accept edge E0.
- ISSUE cycle: ALU operand registers load at edge E1.
- EXEC cycle: ALU result register loads at E2.
- CAPT cycle: `alu_s` is valid and sampled at E3.
- `respX_valid` is high during the cycle after E3; it coincides with IDLE.
- A new accept can occur in that same cycle.
- Latency: accept cycle to response = 4 cycles. Throughput: 1 op per 4 cycles.
- Simultaneous events:
  - A response to X and an accept from X in the same cycle are both legal.
  - The response registers are not overwritten until that new op's CAPT.

## Configuration
- `ULA_ARB_STATS_EN` defined:
  - `cnt0`/`cnt1` increment on each `resp0_valid`/`resp1_valid`, including err responses.
  - Counters wrap FFFF→0000.
- Undefined: no counter logic; `cnt0`/`cnt1` are tied to 0.

## Structure
- Shared package `ula_pkg`:
  - Opcode localparams (OP_ADD 000, OP_SUB 001, OP_XOR 010, OP_NOT 011, OP_EQ 110, OP_NEQ 111).
  - FSM state typedef (IDLE/ISSUE/EXEC/CAPT).
  - Function `op_illegal`.
- One sub-module, `arb_rr2`: 2-way round-robin grant from valids plus the pointer, pointer updated on accept.

## Test plan
- Single op, req0 op 000, a=8'hFF, b=8'h01 → resp0_valid 4 cycles after accept, s=8'h00, flag=1, err=0.
- Both valid from reset: req0 add 8'h7F+8'h01 and req1 xor 8'hF0^8'h0F.
  - Grants go req0 then req1.
  - resp0 s=8'h80, flag=0; then resp1 s=8'hFF, flag=0.
  - The two responses are 4 cycles apart.
- Both held valid continuously for 6 ops → grants alternate 0,1,0,1,0,1; `reqX_ready` is never high outside IDLE.
- req1 op 110, a=b=8'h3C → s=8'h01. Op 111 with the same operands → s=8'h00.
- req0 op 101 → 4-cycle latency, s=8'h00, flag=0, err=1, and the ALU output is ignored.
- `rst` asserted during EXEC → no response; all outputs 0. The next req1 request is accepted as though from reset (pointer favours req0 only under contention).
